// File: rtl/seg7_scan_mux_if.sv
// Bundle between the stopwatch core and the 4-digit scan driver:
// digit patterns / enables in, cathode + anode drive back out.
interface seg7_scan_mux_if;
    logic       en_disp;
    logic [6:0] F;
    logic [6:0] S0;
    logic [6:0] S1;
    logic [6:0] M;
    logic [3:0] dp_mask;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] digit_sel;
    logic       frame_tick;

    modport master (
        output en_disp, F, S0, S1, M, dp_mask,
        input  seg, dp, an, digit_sel, frame_tick
    );

    modport slave (
        input  en_disp, F, S0, S1, M, dp_mask,
        output seg, dp, an, digit_sel, frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit common-anode driver with per-slot blanking,
// frame-coherent shadow latching and optional minutes leading-zero blanking.
module seg7_scan_mux #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          BLANK_LEAD   = 1'b1,
    parameter logic [6:0]  ZERO_GLYPH   = 7'b1000000
) (
    input  logic           Clk,
    input  logic           reset,
    seg7_scan_mux_if.slave disp
);
    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       dsel_reg, dsel_next;
    logic [CNT_W-1:0] cnt_inc;

    logic [6:0] seg_reg, seg_next;
    logic [3:0] an_reg, an_next;
    logic       dp_reg, dp_next;
    logic       tick_reg, tick_next;

    logic       latch;
    logic       lead_zero;
    logic [6:0] pat [4];
    logic [6:0] shadow_pat [4];
    logic [3:0] shadow_dp_reg;

    assign pat[0] = disp.F;
    assign pat[1] = disp.S0;
    assign pat[2] = disp.S1;
    assign pat[3] = disp.M;

    // One shadow register per digit, all loaded together at the frame boundary.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_shadow
            logic [6:0] shadow_reg;

            always_ff @(posedge Clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg <= 7'h7F;
                end else if (latch) begin
                    shadow_reg <= pat[gi];
                end
            end

            assign shadow_pat[gi] = shadow_reg;
        end
    endgenerate

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            shadow_dp_reg <= 4'b0000;
        end else if (latch) begin
            shadow_dp_reg <= disp.dp_mask;
        end
    end

    assign lead_zero = BLANK_LEAD && (shadow_pat[3] == ZERO_GLYPH);
    assign cnt_inc   = cnt_reg + 1'b1;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
            dsel_reg  <= 2'd0;
            seg_reg   <= 7'h7F;
            an_reg    <= 4'b1111;
            dp_reg    <= 1'b1;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dsel_reg  <= dsel_next;
            seg_reg   <= seg_next;
            an_reg    <= an_next;
            dp_reg    <= dp_next;
            tick_reg  <= tick_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dsel_next  = dsel_reg;
        seg_next   = 7'h7F;
        an_next    = 4'b1111;
        dp_next    = 1'b1;
        tick_next  = 1'b0;
        latch      = 1'b0;

        if (!disp.en_disp) begin
            // Disable beats any slot wrap in the same cycle, so no frame_tick.
            state_next = ST_OFF;
            cnt_next   = '0;
            dsel_next  = 2'd0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    dsel_next  = 2'd0;
                end
                ST_BLANK, ST_SHOW: begin
                    latch = (state_reg == ST_BLANK) && (cnt_reg == '0) && (dsel_reg == 2'd0);

                    if (state_reg == ST_SHOW && !(dsel_reg == 2'd3 && lead_zero)) begin
                        an_next  = ~(4'b0001 << dsel_reg);
                        seg_next = shadow_pat[dsel_reg];
                        dp_next  = ~shadow_dp_reg[dsel_reg];
                    end

                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        dsel_next  = dsel_reg + 2'd1;
                        tick_next  = (dsel_reg == 2'd3);
                        state_next = ST_BLANK;
                    end else begin
                        cnt_next   = cnt_inc;
                        state_next = (cnt_inc < BLANK_END) ? ST_BLANK : ST_SHOW;
                    end
                end
                default: begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    dsel_next  = 2'd0;
                end
            endcase
        end
    end

    assign disp.seg        = seg_reg;
    assign disp.an         = an_reg;
    assign disp.dp         = dp_reg;
    assign disp.frame_tick = tick_reg;
    assign disp.digit_sel  = dsel_reg;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with short slots: a position-in-frame model is
// compared every cycle, plus hand-computed checkpoints for each scenario.
module tb_seg7_scan_mux;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam logic [6:0] ZERO = 7'b1000000;

    logic Clk;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    seg7_scan_mux_if dif();

    seg7_scan_mux #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC),
        .BLANK_LEAD  (1'b1),
        .ZERO_GLYPH  (ZERO)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .disp (dif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, got, want);
        end
    endtask

    // Model: the scan is a position p in a 4*DC-cycle frame; digit = p/DC, offset = p%DC.
    bit         m_run;
    int         m_p;
    logic [6:0] m_sh [4];
    logic [3:0] m_shdp;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;
    logic [1:0] e_sel;

    always @(posedge Clk or negedge reset) begin
        int dig;
        int pos;
        if (!reset) begin
            m_run = 1'b1; m_p = 0; m_shdp = 4'b0;
            for (int k = 0; k < 4; k++) m_sh[k] = 7'h7F;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0; e_sel = 2'd0;
        end else if (!dif.en_disp) begin
            m_run = 1'b0; m_p = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0; e_sel = 2'd0;
        end else if (!m_run) begin
            m_run = 1'b1; m_p = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0; e_sel = 2'd0;
        end else begin
            dig = m_p / DC;
            pos = m_p % DC;
            if (m_p == 0) begin
                m_sh[0] = dif.F; m_sh[1] = dif.S0; m_sh[2] = dif.S1; m_sh[3] = dif.M;
                m_shdp  = dif.dp_mask;
            end
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            if (pos >= BC && !(dig == 3 && m_sh[3] == ZERO)) begin
                e_an      = 4'hF;
                e_an[dig] = 1'b0;
                e_seg     = m_sh[dig];
                e_dp      = ~m_shdp[dig];
            end
            e_tick = (m_p == 4 * DC - 1);
            m_p    = (m_p + 1) % (4 * DC);
            e_sel  = 2'(m_p / DC);
        end
    end

    always @(negedge Clk) begin
        chk("an",         dif.an,         e_an);
        chk("seg",        dif.seg,        e_seg);
        chk("dp",         dif.dp,         e_dp);
        chk("frame_tick", dif.frame_tick, e_tick);
        chk("digit_sel",  dif.digit_sel,  e_sel);
        chk("overlap",    ($countones(~dif.an) <= 1), 1);
    end

    task automatic wait_an(input logic [3:0] v, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge Clk);
            if (dif.an === v) ok = 1'b1;
        end
        if (!ok) chk(nm, 0, 1);
    endtask

    task automatic tick_gap(input string nm);
        int  n;
        bit  ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge Clk);
            if (dif.frame_tick) ok = 1'b1;
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge Clk);
                n++;
                if (dif.frame_tick) ok = 1'b1;
            end
        end
        chk(nm, n, 32);
    endtask

    task automatic count_an(input logic [3:0] v, output int n);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            if (dif.an === v) n++;
        end
    endtask

    initial begin
        int n;
        int n13;
        dif.en_disp = 1'b1;
        dif.F = 7'h40; dif.S0 = 7'h79; dif.S1 = 7'h24; dif.M = 7'h30;
        dif.dp_mask = 4'b0000;

        #2 reset = 1'b0;
        #1;
        chk("rst_an",   dif.an, 4'hF);
        chk("rst_seg",  dif.seg, 7'h7F);
        chk("rst_dp",   dif.dp, 1);
        chk("rst_tick", dif.frame_tick, 0);
        chk("rst_sel",  dif.digit_sel, 0);
        repeat (3) @(negedge Clk);
        reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("first_an",  dif.an, 4'b1110);
        chk("first_seg", dif.seg, 7'h40);

        // Basic timing: 2 dark + 6 lit per slot, 32-cycle frames.
        tick_gap("tick_period");
        count_an(4'b1111, n); chk("dark_per_frame", n, 8);
        count_an(4'b1011, n); chk("d2_per_frame", n, 6);

        // Decimal points on digits 1 and 3 only.
        dif.dp_mask = 4'b1010;
        repeat (40) @(negedge Clk);
        n = 0; n13 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            if (dif.dp === 1'b0) begin
                n++;
                if (dif.an === 4'b1101 || dif.an === 4'b0111) n13++;
            end
        end
        chk("dp_low_total", n, 12);
        chk("dp_low_d1d3",  n13, 12);

        // Minutes zero glyph blanks digit 3 for its whole slot.
        dif.M = ZERO;
        repeat (40) @(negedge Clk);
        count_an(4'b0111, n); chk("lead_zero_d3", n, 0);
        count_an(4'b1110, n); chk("lead_zero_d0", n, 6);
        count_an(4'b1111, n); chk("lead_zero_dark", n, 14);
        tick_gap("lead_zero_tick_period");

        // Frame coherence of the shadow latch.
        dif.M = 7'h30; dif.dp_mask = 4'b0000;
        repeat (40) @(negedge Clk);
        wait_an(4'b1011, "wait_d2");
        dif.S0 = 7'h24;
        wait_an(4'b1101, "wait_d1_a");
        chk("s0_after_latch", dif.seg, 7'h24);
        wait_an(4'b1110, "wait_d0");
        dif.S0 = 7'h79;
        wait_an(4'b1101, "wait_d1_b");
        chk("s0_midframe_hidden", dif.seg, 7'h24);
        wait_an(4'b1110, "wait_d0_b");
        wait_an(4'b1101, "wait_d1_c");
        chk("s0_next_frame", dif.seg, 7'h79);

        // Display disable mid-slot, then re-enable.
        wait_an(4'b1011, "wait_d2_off");
        dif.en_disp = 1'b0;
        @(posedge Clk); #1;
        chk("off_an",   dif.an, 4'hF);
        chk("off_tick", dif.frame_tick, 0);
        repeat (40) @(negedge Clk);
        chk("off_sel", dif.digit_sel, 0);
        dif.en_disp = 1'b1;
        repeat (3) @(posedge Clk); #1;
        chk("reen_dark", dif.an, 4'hF);
        @(posedge Clk); #1;
        chk("reen_an",  dif.an, 4'b1110);
        chk("reen_seg", dif.seg, 7'h40);

        // Asynchronous reset in the middle of digit 1.
        wait_an(4'b1101, "wait_d1_rst");
        #2 reset = 1'b0;
        dif.F = 7'h79;
        #1;
        chk("arst_an",  dif.an, 4'hF);
        chk("arst_seg", dif.seg, 7'h7F);
        chk("arst_dp",  dif.dp, 1);
        @(negedge Clk);
        reset = 1'b1;
        repeat (2) @(posedge Clk); #1;
        chk("arst_blank", dif.an, 4'hF);
        @(posedge Clk); #1;
        chk("arst_an_d0",  dif.an, 4'b1110);
        chk("arst_seg_d0", dif.seg, 7'h79);
        repeat (20) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
